// File: rtl/parity_stream_checker.sv
// parity_stream_checker
//   Accumulates XOR parity of operand A or B across a multi-beat frame, applies
//   even/odd mode latched on the first beat, and at frame close compares the
//   result against exp_parity. The result is presented on an ALSU-format word,
//   and a saturating count of errored frames is kept.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   A, B, Sel       operands and operand select (0 = A, 1 = B)
//   in_valid        beat present (no backpressure)
//   in_last         final beat of the frame
//   odd_mode        parity mode, latched on the first beat
//   exp_parity      expected frame parity, sampled on the last beat
//   clr_cnt         clear err_count
//   out             {zeros, frame parity}, held until the next result
//   out_valid       one-cycle pulse per closed frame
//   parity_err      mismatch or overflow, held with out
//   frame_ovf       frame force-closed at MAX_BEATS, held with out
//   err_count       saturating count of errored frames
//   busy            frame in progress
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no frame open; a valid beat opens one (or closes a 1-beat frame)
// ACCUM | frame open, folding beat parity into the accumulator
module parity_stream_checker #(
  parameter int WIDTH     = 4,
  parameter int OUT_W     = 4,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sel,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             odd_mode,
  input  logic             exp_parity,
  input  logic             clr_cnt,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             parity_err,
  output logic             frame_ovf,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0]    MAX_C   = BW'(MAX_BEATS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic             mode_q, mode_d;
  logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_ovf_q, frame_ovf_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic             beat_par;
  logic             close;
  logic             ovf;
  logic             frame_par;
  logic [CNT_W-1:0] cnt_base;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mode_d       = mode_q;
    beat_cnt_d   = beat_cnt_q;
    out_d        = out_q;
    out_valid_d  = 1'b0;
    parity_err_d = parity_err_q;
    frame_ovf_d  = frame_ovf_q;
    close        = 1'b0;
    ovf          = 1'b0;
    beat_par     = Sel ? ^B : ^A;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d      = beat_par;
          mode_d     = odd_mode;
          beat_cnt_d = BW'(1);
          if (in_last) close   = 1'b1;
          else         state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d      = acc_q ^ beat_par;
          beat_cnt_d = beat_cnt_q + BW'(1);
          // in_last wins over the beat limit, so a coinciding close is normal
          if (in_last) begin
            close   = 1'b1;
            state_d = IDLE;
          end else if (beat_cnt_d == MAX_C) begin
            close   = 1'b1;
            ovf     = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    frame_par = acc_d ^ mode_d;

    if (close) begin
      out_d        = '0;
      out_d[0]     = frame_par;
      out_valid_d  = 1'b1;
      frame_ovf_d  = ovf;
      parity_err_d = (frame_par != exp_parity) | ovf;
    end

    // clear takes effect before the increment of a coinciding error close
    cnt_base    = clr_cnt ? '0 : err_count_q;
    err_count_d = cnt_base;
    if (close && parity_err_d && (cnt_base != CNT_MAX))
      err_count_d = cnt_base + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= 1'b0;
      mode_q       <= 1'b0;
      beat_cnt_q   <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_ovf_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      mode_q       <= mode_d;
      beat_cnt_q   <= beat_cnt_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      frame_ovf_q  <= frame_ovf_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign parity_err = parity_err_q;
  assign frame_ovf  = frame_ovf_q;
  assign err_count  = err_count_q;
  assign busy       = (state_q == ACCUM);

endmodule

// File: tb/tb_parity_stream_checker.sv
module tb_parity_stream_checker;

  localparam int WIDTH     = 4;
  localparam int OUT_W     = 4;
  localparam int MAX_BEATS = 4;
  localparam int CNT_W     = 2;
  localparam int CNT_SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] A, B;
  logic             Sel, in_valid, in_last, odd_mode, exp_parity, clr_cnt;
  logic [OUT_W-1:0] out;
  logic             out_valid, parity_err, frame_ovf, busy;
  logic [CNT_W-1:0] err_count;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: frame kept as a list of beat words
  int m_words[$];
  bit m_in_frame;
  bit m_mode;
  int m_out, m_ovalid, m_perr, m_ovf, m_cnt;

  parity_stream_checker #(
    .WIDTH(WIDTH), .OUT_W(OUT_W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .Sel(Sel),
    .in_valid(in_valid), .in_last(in_last), .odd_mode(odd_mode),
    .exp_parity(exp_parity), .clr_cnt(clr_cnt),
    .out(out), .out_valid(out_valid), .parity_err(parity_err),
    .frame_ovf(frame_ovf), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int cnt;
    int ones;
    int w;
    if (rst) begin
      m_words.delete();
      m_in_frame = 0; m_mode = 0;
      m_out = 0; m_ovalid = 0; m_perr = 0; m_ovf = 0; m_cnt = 0;
      return;
    end
    m_ovalid = 0;
    cnt = clr_cnt ? 0 : m_cnt;
    if (in_valid) begin
      if (!m_in_frame) begin
        m_words.delete();
        m_mode = odd_mode;
      end
      w = Sel ? int'(B) : int'(A);
      m_words.push_back(w);
      if (in_last || m_words.size() == MAX_BEATS) begin
        ones = 0;
        foreach (m_words[i]) ones += $countones(m_words[i]);
        m_out    = (ones % 2) ^ int'(m_mode);
        m_ovf    = in_last ? 0 : 1;
        m_perr   = ((m_out != int'(exp_parity)) || m_ovf) ? 1 : 0;
        m_ovalid = 1;
        m_in_frame = 0;
        if (m_perr && cnt < CNT_SAT) cnt++;
      end else begin
        m_in_frame = 1;
      end
    end
    m_cnt = cnt;
  endtask

  task automatic cyc(input bit v, input bit last, input bit sel,
                     input int a, input int b, input bit mode,
                     input bit ep, input bit clr, input bit r);
    @(negedge clk);
    in_valid = v; in_last = last; Sel = sel;
    A = WIDTH'(a); B = WIDTH'(b); odd_mode = mode;
    exp_parity = ep; clr_cnt = clr; rst = r;
    model_step();
    @(posedge clk);
    #1;
    check("out",        int'(out),        m_out);
    check("out_valid",  int'(out_valid),  m_ovalid);
    check("parity_err", int'(parity_err), m_perr);
    check("frame_ovf",  int'(frame_ovf),  m_ovf);
    check("err_count",  int'(err_count),  m_cnt);
    check("busy",       int'(busy),       int'(m_in_frame));
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; A = 0; B = 0; Sel = 0; in_valid = 0; in_last = 0;
    odd_mode = 0; exp_parity = 0; clr_cnt = 0;

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_out", int'(out), 0);
    check("rst_cnt", int'(err_count), 0);
    check("rst_busy", int'(busy), 0);

    // single beat, even mode, A=0111 -> parity 1, matches
    cyc(1, 1, 0, 4'b0111, 0, 0, 1, 0, 0);
    check("single_out", int'(out), 1);
    check("single_ov", int'(out_valid), 1);
    check("single_perr", int'(parity_err), 0);
    idle();
    check("single_ov_pulse", int'(out_valid), 0);
    check("single_hold", int'(out), 1);

    // multi-beat on B with a gap: 0011,0001,1000 -> parity 0
    cyc(1, 0, 1, 0, 4'b0011, 0, 1, 0, 0);
    check("multi_busy1", int'(busy), 1);
    idle();
    check("multi_busy_gap", int'(busy), 1);
    cyc(1, 0, 1, 0, 4'b0001, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 4'b1000, 0, 0, 0, 0);
    check("multi_out", int'(out), 0);
    check("multi_perr", int'(parity_err), 0);
    check("multi_busy_end", int'(busy), 0);

    // odd mode mismatch, then clear coinciding with an error close
    cyc(1, 1, 0, 4'b1111, 0, 1, 0, 0, 0);
    check("odd_out", int'(out), 1);
    check("odd_perr", int'(parity_err), 1);
    check("odd_cnt", int'(err_count), 1);
    cyc(1, 1, 0, 4'b1111, 0, 1, 0, 0, 0);
    check("odd_cnt2", int'(err_count), 2);
    cyc(1, 1, 0, 4'b1111, 0, 1, 0, 1, 0);
    check("clr_err_cnt", int'(err_count), 1);

    // saturation sequence 1,2,3,3,3
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("clr_only", int'(err_count), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 4'b1111, 0, 1, 0, 0, 0);
      check("sat_seq", int'(err_count), (i < 3) ? i + 1 : 3);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // overflow at MAX_BEATS, exp_parity ignored
    for (int i = 0; i < MAX_BEATS; i++) begin
      cyc(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
      check("ovf_ov", int'(out_valid), (i == MAX_BEATS - 1) ? 1 : 0);
    end
    check("ovf_flag", int'(frame_ovf), 1);
    check("ovf_perr", int'(parity_err), 1);
    check("ovf_busy_idle", int'(busy), 0);
    cyc(1, 0, 0, 4'b0001, 0, 0, 0, 0, 0);
    check("ovf_next_busy", int'(busy), 1);
    cyc(1, 1, 0, 4'b0001, 0, 0, 0, 0, 0);
    check("ovf_next_out", int'(out), 0);

    // in_last coinciding with the beat limit is a normal close
    for (int i = 0; i < MAX_BEATS; i++)
      cyc(1, (i == MAX_BEATS - 1), 0, 4'b0001, 0, 0, 0, 0, 0);
    check("limit_last_ovf", int'(frame_ovf), 0);
    check("limit_last_perr", int'(parity_err), 0);

    // reset mid-frame discards the partial frame
    cyc(1, 0, 0, 4'b0001, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 4'b0011, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_mid_ov", int'(out_valid), 0);
    check("rst_mid_busy", int'(busy), 0);
    cyc(1, 1, 0, 4'b0001, 0, 0, 1, 0, 0);
    check("rst_mid_out", int'(out), 1);
    check("rst_mid_perr", int'(parity_err), 0);
    idle();
    check("rst_mid_once", int'(out_valid), 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3),
          $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/parity_stream_checker.md
Name: parity_stream_checker

Overview:
Parametrised, clocked successor to the ALSU combinational parity checker. It accumulates XOR parity of operand A or B across a multi-beat frame and applies even or odd mode. At frame end it compares the result against an expected parity bit, reports the result on an ALSU-format output word, and keeps a saturating error count. It sits in the ALSU datapath as the parity/integrity stage for streamed operands.

Parameters:
WIDTH, 4, operand width of A and B (>=1)
OUT_W, 4, result bus width; parity in bit 0, bits OUT_W-1..1 zero (>=1)
MAX_BEATS, 16, maximum beats per frame before forced close (>=2)
CNT_W, 8, error counter width (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
A  input  WIDTH  operand A
B  input  WIDTH  operand B
Sel  input  1  0 selects A, 1 selects B, sampled every valid beat
in_valid  input  1  beat present this cycle; no backpressure, every valid beat is consumed
in_last  input  1  final beat of frame, qualified by in_valid
odd_mode  input  1  0 even parity, 1 odd parity; latched on first beat of frame
exp_parity  input  1  expected frame parity, sampled on the last beat
clr_cnt  input  1  clear err_count
out  output  OUT_W  {zeros, frame parity}; holds until next result
out_valid  output  1  one-cycle pulse per closed frame
parity_err  output  1  result mismatch or overflow; valid with out_valid, holds with out
frame_ovf  output  1  frame force-closed at MAX_BEATS; valid with out_valid, holds with out
err_count  output  CNT_W  saturating count of frames with parity_err
busy  output  1  1 while state is ACCUM

Behaviour:
- Reset: state IDLE; out=0, out_valid=0, parity_err=0, frame_ovf=0, err_count=0, busy=0; internal accumulator, beat count and latched mode cleared.
- Reset mid-frame discards the partial frame. No out_valid is produced.
- Beat word = Sel ? B : A. Beat parity is the XOR reduction of the word.
- FSM states: IDLE, ACCUM.
- IDLE, in_valid=0: stay in IDLE.
- IDLE, in_valid=1: accumulator = beat parity; latch odd_mode; beat count = 1.
  - If in_last=1, close the frame (single-beat frame) and stay in IDLE.
  - Otherwise go to ACCUM.
- ACCUM, in_valid=0: hold all state (gaps allowed).
- ACCUM, in_valid=1: accumulator ^= beat parity; beat count += 1.
  - If in_last=1, close the frame and go to IDLE.
  - Else if the new beat count equals MAX_BEATS, force-close with frame_ovf=1 and go to IDLE.
  - If in_last and the count limit coincide on the same beat, treat it as a normal close (frame_ovf=0).
- Close latency: out, out_valid, parity_err and frame_ovf update on the edge after the closing beat (1 cycle).
- Result value: frame parity = accumulator ^ latched odd_mode.
- parity_err = (frame parity != exp_parity) OR frame_ovf. On overflow, exp_parity is ignored.
- err_count increments on a close with parity_err=1 and saturates at 2^CNT_W-1 (no wrap).
- clr_cnt=1 zeroes err_count. If clr_cnt coincides with an error close, err_count becomes 1 (clear first, then count).
- A beat arriving in the same cycle out_valid is asserted is accepted as the first beat of a new frame. Back-to-back frames need no idle cycle.
- odd_mode changes mid-frame are ignored. exp_parity is ignored on non-last beats.

Test Plan:
- Single beat: Sel=0, A=4'b0111, in_last=1, odd_mode=0, exp_parity=1 -> next cycle out=4'b0001, out_valid=1 for exactly 1 cycle, parity_err=0, err_count=0.
- Multi-beat with gap: Sel=1, B=0011, idle cycle, B=0001, B=1000 (last), exp_parity=0 -> out=4'b0000, parity_err=0, busy=1 from the first beat until the close.
- Odd mode plus mismatch: A=1111 single beat, odd_mode=1, exp_parity=0 -> out=4'b0001, parity_err=1, err_count=1. Then clr_cnt together with another error close -> err_count=1.
- Saturation: CNT_W=2, five consecutive error frames -> err_count sequence 1,2,3,3,3.
- Overflow: MAX_BEATS=4, four valid beats with in_last=0 -> out_valid after the fourth beat, frame_ovf=1, parity_err=1. A fifth beat starts a new frame (busy=1).
- Reset mid-frame: two beats, then rst=1 for 1 cycle, then a single-beat frame A=0001 (last) -> exactly one out_valid, out=4'b0001. No stale accumulation.
